// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one outstanding request, fixed-latency
// response over valid/ready, with bench preload and live inspection ports.
module dmem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [31:0] init_values [DEPTH],
    output logic [31:0] mem_check   [DEPTH]
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]      t_addr;
    logic             t_we;
    logic [3:0]       t_wstrb;
    logic [31:0]      t_wdata;
    logic             t_in_range;
    logic             t_err;
    logic [IDX_W-1:0] t_idx;
    logic [31:0]      t_word;
    logic [31:0]      t_merged;
    logic             commit;

    // With LATENCY==1 the commit lands on the accept edge, before the fields are latched,
    // so the transaction is taken straight from the request port while IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            t_addr  = req_addr;
            t_we    = req_we;
            t_wstrb = req_wstrb;
            t_wdata = req_wdata;
        end else begin
            t_addr  = addr_q;
            t_we    = we_q;
            t_wstrb = wstrb_q;
            t_wdata = wdata_q;
        end
    end

    // Out-of-range addresses never reach the array index, so no aliasing and no X reads.
    assign t_in_range = (t_addr[31:2] < 30'(DEPTH));
    assign t_err      = (t_addr[1:0] != 2'b00) || !t_in_range;
    assign t_idx      = t_in_range ? t_addr[IDX_W+1:2] : '0;
    assign t_word     = mem_q[t_idx];

    always_comb begin
        t_merged = t_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (t_wstrb[b]) begin
                t_merged[8*b +: 8] = t_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rdata_d = (t_we || t_err) ? '0 : t_word;
            err_d   = t_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mem_q   <= init_values;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (commit && t_we && !t_err) begin
                mem_q[t_idx] <= t_merged;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_check = mem_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance are
// checked against a byte-addressed memory model kept in the bench.
module tb_dmem_responder;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [3:0]  req_wstrb [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [31:0] init_v [DEPTH];
    logic [31:0] m0 [DEPTH];
    logic [31:0] m1 [DEPTH];

    logic [7:0]  mb [2][DEPTH*4];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_we(req_we[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .init_values(init_v), .mem_check(m0)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_we(req_we[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .init_values(init_v), .mem_check(m1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] getm(input int u, input int i);
        return (u == 0) ? m0[i] : m1[i];
    endfunction

    function automatic logic [31:0] model_word(input int u, input int i);
        return {mb[u][4*i+3], mb[u][4*i+2], mb[u][4*i+1], mb[u][4*i]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < DEPTH; i++)
                for (int b = 0; b < 4; b++)
                    mb[u][4*i+b] = init_v[i][8*b +: 8];
    endtask

    task automatic chk_mem(input int u);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem%0d[%0d]", u, i), getm(u, i), model_word(u, i));
    endtask

    // Request is driven just after edge N and accepted on edge N+1; the response
    // is visible after edge N+LATENCY and then held for 'hold' cycles of backpressure.
    // With 'keep', a different store stays asserted throughout and must be ignored.
    task automatic do_txn(input int u, input logic [31:0] a, input logic we, input logic [3:0] st,
                          input logic [31:0] wd, input int hold, input bit keep);
        logic [31:0] er;
        logic        ee;
        int          idx;
        int          lat;
        lat = lat_of(u);
        ee  = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        er  = '0;
        idx = int'(a >> 2);
        if (!ee) begin
            if (!we) er = model_word(u, idx);
            else
                for (int b = 0; b < 4; b++)
                    if (st[b]) mb[u][4*idx+b] = wd[8*b +: 8];
        end

        @(negedge clk);
        chk("ready_idle", req_ready[u], 1'b1);
        req_valid[u] = 1'b1; req_addr[u] = a; req_we[u] = we; req_wstrb[u] = st; req_wdata[u] = wd;
        @(negedge clk);
        if (keep) begin
            req_we[u] = 1'b1; req_addr[u] = 32'h0; req_wstrb[u] = 4'hF; req_wdata[u] = 32'hBADBAD00;
        end else begin
            req_valid[u] = 1'b0;
        end
        for (int j = 1; j < lat; j++) begin
            chk("wait_valid", rsp_valid[u], 1'b0);
            chk("wait_ready", req_ready[u], 1'b0);
            @(negedge clk);
        end
        chk("rsp_valid", rsp_valid[u], 1'b1);
        chk("rsp_rdata", rsp_rdata[u], er);
        chk("rsp_err", rsp_err[u], ee);
        chk("busy_ready", req_ready[u], 1'b0);
        if (!ee) chk("mem_commit", getm(u, idx), model_word(u, idx));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid[u], 1'b1);
            chk("hold_rdata", rsp_rdata[u], er);
            chk("hold_err", rsp_err[u], ee);
            chk("hold_ready", req_ready[u], 1'b0);
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        req_valid[u] = 1'b0;
        chk("done_valid", rsp_valid[u], 1'b0);
        chk("done_ready", req_ready[u], 1'b1);
        chk("done_rdata", rsp_rdata[u], 32'h0);
        chk("done_err", rsp_err[u], 1'b0);
    endtask

    initial begin
        int          acc_cyc[$];
        logic [31:0] rsp_q[$];
        logic [31:0] a;
        int          r;

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_addr[u] = '0; req_we[u] = 1'b0;
            req_wstrb[u] = '0; req_wdata[u] = '0; rsp_ready[u] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) init_v[i] = $urandom;
        init_v[2] = 32'hAABBCCDD;
        init_v[3] = 32'hDEADBEEF;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", req_ready[u], 1'b1);
            chk("rst_valid", rsp_valid[u], 1'b0);
            chk("rst_rdata", rsp_rdata[u], 32'h0);
            chk("rst_err", rsp_err[u], 1'b0);
            chk_mem(u);
        end

        // Directed cases on the LATENCY=2 instance.
        do_txn(0, 32'h0C, 1'b0, 4'h0, 32'h0, 0, 1'b0);
        chk("load_deadbeef", model_word(0, 3), 32'hDEADBEEF);
        do_txn(0, 32'h08, 1'b1, 4'b0101, 32'h11223344, 1, 1'b0);
        chk("store_merge", getm(0, 2), 32'hAA22CC44);
        do_txn(0, 32'h06, 1'b0, 4'h0, 32'h0, 0, 1'b0);
        do_txn(0, 32'h80, 1'b1, 4'hF, 32'hFFFFFFFF, 0, 1'b0);
        do_txn(0, 32'h10, 1'b1, 4'h0, 32'h12345678, 0, 1'b0);
        do_txn(0, 32'h0C, 1'b0, 4'h0, 32'h0, 5, 1'b1);
        chk_mem(0);

        // Reset while a store to word 0 waits: it must neither write nor respond.
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h0; req_we[0] = 1'b1;
        req_wstrb[0] = 4'hF; req_wdata[0] = 32'h5A5A5A5A;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("rstw_inwait", req_ready[0], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rstw_mem0", m0[0], init_v[0]);
        chk("rstw_ready", req_ready[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("rstw_novalid", rsp_valid[0], 1'b0);
            @(negedge clk);
        end
        chk("rstw_mem0_late", m0[0], init_v[0]);

        // LATENCY=1 back-to-back store then load with rsp_ready tied high.
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h10; req_we[1] = 1'b1;
        req_wstrb[1] = 4'hF; req_wdata[1] = 32'h00000055;
        for (int c = 0; c < 12; c++) begin
            bit acc;
            acc = req_valid[1] && req_ready[1];
            @(posedge clk);
            if (acc) acc_cyc.push_back(c);
            @(negedge clk);
            if (rsp_valid[1]) rsp_q.push_back(rsp_rdata[1]);
            if (acc) begin
                if (acc_cyc.size() == 1) begin
                    req_we[1] = 1'b0; req_wdata[1] = '0;
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
        end
        rsp_ready[1] = 1'b0;
        mb[1][16] = 8'h55; mb[1][17] = 8'h00; mb[1][18] = 8'h00; mb[1][19] = 8'h00;
        chk("b2b_accepts", acc_cyc.size(), 2);
        chk("b2b_spacing", (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 2);
        chk("b2b_rsps", rsp_q.size(), 2);
        chk("b2b_store_rdata", (rsp_q.size() > 0) ? rsp_q[0] : 32'hFFFFFFFF, 32'h0);
        chk("b2b_load_rdata", (rsp_q.size() > 1) ? rsp_q[1] : 32'hFFFFFFFF, 32'h00000055);
        chk_mem(1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
            else if (r == 1) a = $urandom_range(DEPTH, 1000) << 2;
            else if (r == 2) a = ($urandom | 32'h8000_0000) & ~32'h3;
            else             a = $urandom_range(0, DEPTH - 1) << 2;
            do_txn(n % 2, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        chk_mem(0);
        chk_mem(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
